axis_dest_demux: RTL and testbench

Packet-granular AXI4-Stream demultiplexer: one input stream fans out to M_COUNT output streams, with the destination port taken from the upper bits of input tdest. It is the receive-side counterpart of the arbitrated mux, which prepends the source port index to tid; this block strips the port index from tdest and routes each whole frame to the matching port. Frames addressed to a nonexistent port are consumed and dropped. A single registered skid stage shared by all outputs gives full throughput and registered tready/tvalid.

---
 rtl/axis_dest_demux.sv | 193 +++++++++++++++++++
 tb/tb_axis_dest_demux.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_dest_demux.sv
// Packet-granular AXI4-Stream demux: routes whole frames by the upper tdest bits and drops frames to absent ports.
// Latency: one cycle from input accept to output tvalid through a shared main/temp skid stage.
// Backpressure: s_axis_tready is registered; a stall on the target port parks at most one beat in temp.
module axis_dest_demux #(
    parameter int M_COUNT      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int KEEP_ENABLE  = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH   = (DATA_WIDTH + 7) / 8,
    parameter int ID_ENABLE    = 0,
    parameter int ID_WIDTH     = 8,
    parameter int M_DEST_WIDTH = 8,
    parameter int S_DEST_WIDTH = M_DEST_WIDTH + $clog2(M_COUNT),
    parameter int USER_ENABLE  = 1,
    parameter int USER_WIDTH   = 1,
    parameter int LAST_ENABLE  = 1
) (
    input  logic                             clk,
    input  logic                             rst,

    input  logic [DATA_WIDTH-1:0]            s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]            s_axis_tkeep,
    input  logic                             s_axis_tvalid,
    output logic                             s_axis_tready,
    input  logic                             s_axis_tlast,
    input  logic [ID_WIDTH-1:0]              s_axis_tid,
    input  logic [S_DEST_WIDTH-1:0]          s_axis_tdest,
    input  logic [USER_WIDTH-1:0]            s_axis_tuser,

    output logic [M_COUNT*DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [M_COUNT*KEEP_WIDTH-1:0]    m_axis_tkeep,
    output logic [M_COUNT-1:0]               m_axis_tvalid,
    input  logic [M_COUNT-1:0]               m_axis_tready,
    output logic [M_COUNT-1:0]               m_axis_tlast,
    output logic [M_COUNT*ID_WIDTH-1:0]      m_axis_tid,
    output logic [M_COUNT*M_DEST_WIDTH-1:0]  m_axis_tdest,
    output logic [M_COUNT*USER_WIDTH-1:0]    m_axis_tuser,

    output logic                             stat_drop
);

    localparam int SEL_WIDTH = $clog2(M_COUNT);
    localparam logic [SEL_WIDTH:0] PORT_LIMIT = (SEL_WIDTH + 1)'(M_COUNT);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]   data;
        logic [KEEP_WIDTH-1:0]   keep;
        logic                    last;
        logic [ID_WIDTH-1:0]     id;
        logic [M_DEST_WIDTH-1:0] dest;
        logic [USER_WIDTH-1:0]   user;
    } beat_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t               state, state_next;
    logic [SEL_WIDTH-1:0] port_reg, port_next;
    logic                 drop_next;

    logic [SEL_WIDTH-1:0] sel;
    logic                 sel_ok;
    logic                 in_last;
    logic                 accept;
    logic                 in_vld;
    logic [SEL_WIDTH-1:0] in_port;
    beat_t                in_beat;

    logic                 ready_int_reg;
    logic                 ready_int_early;
    logic                 main_xfer;
    logic                 main_vld, temp_vld;
    logic [SEL_WIDTH-1:0] main_port, temp_port;
    beat_t                main_beat, temp_beat;

    // Port index lives in the top bits of tdest; the low bits pass through as output tdest.
    assign sel     = s_axis_tdest[S_DEST_WIDTH-1 -: SEL_WIDTH];
    assign sel_ok  = ({1'b0, sel} < PORT_LIMIT);
    assign in_last = (LAST_ENABLE != 0) ? s_axis_tlast : 1'b1;
    assign accept  = s_axis_tvalid & ready_int_reg;

    assign s_axis_tready = ready_int_reg;

    // Assemble the beat presented to the skid stage, masking disabled side channels.
    always_comb begin
        in_beat      = '0;
        in_beat.data = s_axis_tdata;
        in_beat.keep = (KEEP_ENABLE != 0) ? s_axis_tkeep : '1;
        in_beat.last = in_last;
        in_beat.id   = (ID_ENABLE != 0) ? s_axis_tid : '0;
        in_beat.dest = s_axis_tdest[M_DEST_WIDTH-1:0];
        in_beat.user = (USER_ENABLE != 0) ? s_axis_tuser : '0;
    end

    // Frame FSM: route on the first beat, then hold that port (or keep dropping) until tlast.
    always_comb begin
        state_next = state;
        port_next  = port_reg;
        drop_next  = 1'b0;
        in_vld     = 1'b0;
        in_port    = port_reg;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (sel_ok) begin
                        in_vld    = 1'b1;
                        in_port   = sel;
                        port_next = sel;
                        if (!in_last) state_next = FWD;
                    end else begin
                        drop_next = 1'b1;
                        if (!in_last) state_next = DROP;
                    end
                end
            end
            FWD: begin
                in_vld = accept;
                if (accept && in_last) state_next = IDLE;
            end
            DROP: begin
                if (accept && in_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A transfer out of main frees a slot; with both slots empty there is room regardless.
    assign main_xfer       = |(m_axis_tready & m_axis_tvalid);
    assign ready_int_early = main_xfer | (!main_vld & !temp_vld);

    // Control state: FSM, drop pulse, registered ready and the skid valid/port bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            port_reg      <= '0;
            stat_drop     <= 1'b0;
            ready_int_reg <= 1'b0;
            main_vld      <= 1'b0;
            temp_vld      <= 1'b0;
            main_port     <= '0;
            temp_port     <= '0;
        end else begin
            state         <= state_next;
            port_reg      <= port_next;
            stat_drop     <= drop_next;
            ready_int_reg <= ready_int_early;
            if (ready_int_reg) begin
                if (main_xfer || !main_vld) begin
                    main_vld  <= in_vld;
                    main_port <= in_port;
                end else begin
                    temp_vld  <= in_vld;
                    temp_port <= in_port;
                end
            end else if (main_xfer) begin
                main_vld  <= temp_vld;
                main_port <= temp_port;
                temp_vld  <= 1'b0;
            end
        end
    end

    // Skid payload moves alongside the valid bits; contents are don't-care while invalid.
    always_ff @(posedge clk) begin
        if (ready_int_reg) begin
            if (main_xfer || !main_vld) begin
                main_beat <= in_beat;
            end else begin
                temp_beat <= in_beat;
            end
        end else if (main_xfer) begin
            main_beat <= temp_beat;
        end
    end

    // Only the port held in main sees tvalid; payload is shared by all ports.
    always_comb begin
        m_axis_tvalid = '0;
        for (int p = 0; p < M_COUNT; p++) begin
            if (main_vld && (main_port == SEL_WIDTH'(p))) m_axis_tvalid[p] = 1'b1;
        end
    end

    assign m_axis_tdata = {M_COUNT{main_beat.data}};
    assign m_axis_tkeep = {M_COUNT{main_beat.keep}};
    assign m_axis_tlast = {M_COUNT{main_beat.last}};
    assign m_axis_tid   = {M_COUNT{main_beat.id}};
    assign m_axis_tdest = {M_COUNT{main_beat.dest}};
    assign m_axis_tuser = {M_COUNT{main_beat.user}};

endmodule

// File: tb/tb_axis_dest_demux.sv
// Bench for axis_dest_demux: a 3-port instance with frame routing and a 2-port instance with tlast ignored.
// Stimulus pushes expected beats into per-instance queues; forked monitors pop and compare on each output handshake.
// Downstream ready is held high except for the randomised port-1 stall section.
module tb_axis_dest_demux;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;

    // Free-running cycle counter used to measure latency and throughput.
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: 3 ports, 10-bit input tdest, so sel==3 is a nonexistent port.
    logic [7:0]  s_tdata;
    logic [0:0]  s_tkeep;
    logic        s_tvalid, s_tready, s_tlast;
    logic [7:0]  s_tid;
    logic [9:0]  s_tdest;
    logic [0:0]  s_tuser;
    logic [23:0] m_tdata;
    logic [2:0]  m_tkeep, m_tvalid, m_tready, m_tlast, m_tuser;
    logic [23:0] m_tid, m_tdest;
    logic        stat_drop;

    // Instance B: 2 ports, tlast ignored.
    logic [7:0]  b_tdata;
    logic [0:0]  b_tkeep;
    logic        b_tvalid, b_tready, b_tlast;
    logic [7:0]  b_tid;
    logic [8:0]  b_tdest;
    logic [0:0]  b_tuser;
    logic [15:0] b_mdata, b_mid, b_mdest;
    logic [1:0]  b_mkeep, b_mvalid, b_mready, b_mlast, b_muser;
    logic        b_stat_drop;

    axis_dest_demux #(.M_COUNT(3), .DATA_WIDTH(8), .M_DEST_WIDTH(8), .LAST_ENABLE(1)) dut_a (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
        .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
        .m_axis_tdest(m_tdest), .m_axis_tuser(m_tuser), .stat_drop(stat_drop)
    );

    axis_dest_demux #(.M_COUNT(2), .DATA_WIDTH(8), .M_DEST_WIDTH(8), .LAST_ENABLE(0)) dut_b (
        .clk(clk), .rst(rst),
        .s_axis_tdata(b_tdata), .s_axis_tkeep(b_tkeep), .s_axis_tvalid(b_tvalid),
        .s_axis_tready(b_tready), .s_axis_tlast(b_tlast), .s_axis_tid(b_tid),
        .s_axis_tdest(b_tdest), .s_axis_tuser(b_tuser),
        .m_axis_tdata(b_mdata), .m_axis_tkeep(b_mkeep), .m_axis_tvalid(b_mvalid),
        .m_axis_tready(b_mready), .m_axis_tlast(b_mlast), .m_axis_tid(b_mid),
        .m_axis_tdest(b_mdest), .m_axis_tuser(b_muser), .stat_drop(b_stat_drop)
    );

    typedef struct {
        int         port;
        logic [7:0] data;
        logic [7:0] dest;
        logic       last;
        logic       user;
        int         acc;
        int         maxlat;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;
    int   drops = 0;
    int   max_fill = 0;
    bit   rand_rdy = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) m_tready[1] = 1'($urandom_range(0, 1));
    endtask

    task automatic send_a(input logic [7:0] d, input logic [9:0] dst, input logic l,
                          input logic u, input int port, input int maxlat);
        int   n;
        exp_t e;
        s_tdata = d; s_tdest = dst; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
        n = 0;
        while (!s_tready && n < 200) begin tick(); n++; end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL send_a_timeout data=%h ready stayed 0, required 1", d);
        end
        tick();
        if (port >= 0) begin
            e.port = port; e.data = d; e.dest = dst[7:0]; e.last = l; e.user = u;
            e.acc = cyc; e.maxlat = maxlat;
            qa.push_back(e);
        end
        s_tvalid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] d, input logic [8:0] dst, input int port);
        int   n;
        exp_t e;
        b_tdata = d; b_tdest = dst; b_tlast = 1'b0; b_tvalid = 1'b1;
        n = 0;
        while (!b_tready && n < 200) begin tick(); n++; end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL send_b_timeout data=%h ready stayed 0, required 1", d);
        end
        tick();
        e.port = port; e.data = d; e.dest = dst[7:0]; e.last = 1'b1; e.user = 1'b0;
        e.acc = cyc; e.maxlat = 0;
        qb.push_back(e);
        b_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 1000) begin tick(); n++; end
        chk("drain_done", int'(n < 1000), 1);
    endtask

    task automatic mon_a();
        exp_t e;
        int   lat;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (qa.size() > max_fill) max_fill = qa.size();
                if (stat_drop) drops++;
                chk("a_onehot", int'($countones(m_tvalid) <= 1), 1);
                for (int p = 0; p < 3; p++) begin
                    if (m_tvalid[p] && m_tready[p]) begin
                        checks++;
                        if (qa.size() == 0) begin
                            errors++;
                            $display("FAIL a_unexpected port=%0d data=%h, required no beat", p, m_tdata[p*8 +: 8]);
                        end else begin
                            e = qa.pop_front();
                            lat = cyc - e.acc;
                            if (p != e.port || m_tdata[p*8 +: 8] != e.data || m_tdest[p*8 +: 8] != e.dest ||
                                m_tlast[p] != e.last || m_tuser[p] != e.user || m_tkeep[p] != 1'b1 ||
                                m_tid[p*8 +: 8] != 8'h00 || lat > e.maxlat) begin
                                errors++;
                                $display("FAIL a_beat got port=%0d data=%h dest=%h last=%b user=%b keep=%b id=%h lat=%0d exp port=%0d data=%h dest=%h last=%b user=%b keep=1 id=00 lat<=%0d",
                                         p, m_tdata[p*8 +: 8], m_tdest[p*8 +: 8], m_tlast[p], m_tuser[p], m_tkeep[p],
                                         m_tid[p*8 +: 8], lat, e.port, e.data, e.dest, e.last, e.user, e.maxlat);
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic mon_b();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("b_onehot", int'($countones(b_mvalid) <= 1), 1);
                for (int p = 0; p < 2; p++) begin
                    if (b_mvalid[p] && b_mready[p]) begin
                        checks++;
                        if (qb.size() == 0) begin
                            errors++;
                            $display("FAIL b_unexpected port=%0d data=%h, required no beat", p, b_mdata[p*8 +: 8]);
                        end else begin
                            e = qb.pop_front();
                            if (p != e.port || b_mdata[p*8 +: 8] != e.data || b_mdest[p*8 +: 8] != e.dest ||
                                b_mlast[p] != 1'b1 || b_mkeep[p] != 1'b1 || b_muser[p] != 1'b0 ||
                                b_mid[p*8 +: 8] != 8'h00 || (cyc - e.acc) > e.maxlat) begin
                                errors++;
                                $display("FAIL b_beat got port=%0d data=%h dest=%h last=%b lat=%0d exp port=%0d data=%h dest=%h last=1 lat=0",
                                         p, b_mdata[p*8 +: 8], b_mdest[p*8 +: 8], b_mlast[p], cyc - e.acc,
                                         e.port, e.data, e.dest);
                            end
                        end
                    end
                end
                if (b_stat_drop) begin
                    checks++; errors++;
                    $display("FAIL b_stat_drop actual=1 required=0");
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int d0;
        rst = 1'b1;
        s_tdata = '0; s_tkeep = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tid = '0; s_tdest = '0; s_tuser = '0;
        b_tdata = '0; b_tkeep = 1'b1; b_tvalid = 1'b0; b_tlast = 1'b0; b_tid = '0; b_tdest = '0; b_tuser = '0;
        m_tready = 3'b111;
        b_mready = 2'b11;
        fork
            mon_a();
            mon_b();
        join_none

        // Reset state and ready rising one cycle after release.
        repeat (3) tick();
        chk("rst_m_tvalid", int'(m_tvalid), 0);
        chk("rst_s_tready", int'(s_tready), 0);
        chk("rst_stat_drop", int'(stat_drop), 0);
        chk("rst_b_tvalid", int'(b_mvalid), 0);
        rst = 1'b0;
        chk("rel_s_tready_low", int'(s_tready), 0);
        tick();
        chk("rel_s_tready_high", int'(s_tready), 1);

        // Three back-to-back 3-beat frames to ports 0, 1, 2 with one-cycle latency and no bubbles.
        t0 = cyc;
        send_a(8'h11, 10'h005, 1'b0, 1'b0, 0, 0);
        send_a(8'h12, 10'h005, 1'b0, 1'b1, 0, 0);
        send_a(8'h13, 10'h005, 1'b1, 1'b0, 0, 0);
        send_a(8'h14, 10'h1AA, 1'b0, 1'b1, 1, 0);
        send_a(8'h15, 10'h1AA, 1'b0, 1'b0, 1, 0);
        send_a(8'h16, 10'h1AA, 1'b1, 1'b1, 1, 0);
        send_a(8'h17, 10'h2FF, 1'b0, 1'b0, 2, 0);
        send_a(8'h18, 10'h2FF, 1'b0, 1'b0, 2, 0);
        send_a(8'h19, 10'h2FF, 1'b1, 1'b1, 2, 0);
        chk("t1_cycles", cyc - t0, 9);
        drain();

        // Mid-frame tdest port bits change: frame stays on port 2; next frame re-routes.
        send_a(8'h21, 10'h210, 1'b0, 1'b0, 2, 0);
        send_a(8'h22, 10'h111, 1'b0, 1'b0, 2, 0);
        send_a(8'h23, 10'h112, 1'b1, 1'b0, 2, 0);
        send_a(8'h24, 10'h120, 1'b1, 1'b0, 1, 0);
        drain();

        // Frame to nonexistent port 3: consumed at full rate, one drop pulse, then normal traffic.
        d0 = drops;
        t0 = cyc;
        send_a(8'h31, 10'h300, 1'b0, 1'b0, -1, 0);
        chk("t3_drop_pulse", int'(stat_drop), 1);
        send_a(8'h32, 10'h301, 1'b0, 1'b0, -1, 0);
        chk("t3_drop_once", int'(stat_drop), 0);
        send_a(8'h33, 10'h0AB, 1'b0, 1'b0, -1, 0);
        send_a(8'h34, 10'h3CD, 1'b1, 1'b0, -1, 0);
        chk("t3_drop_cycles", cyc - t0, 4);
        send_a(8'h35, 10'h044, 1'b0, 1'b1, 0, 0);
        send_a(8'h36, 10'h045, 1'b1, 1'b0, 0, 0);
        send_a(8'h37, 10'h3EE, 1'b1, 1'b0, -1, 0);
        chk("t3_single_drop_pulse", int'(stat_drop), 1);
        send_a(8'h38, 10'h007, 1'b1, 1'b1, 0, 0);
        drain();
        chk("t3_drop_count", drops - d0, 2);

        // Random 50% ready on port 1 with input always valid: order kept, skid never over two.
        max_fill = 0;
        rand_rdy = 1'b1;
        for (int i = 0; i < 100; i++) begin
            send_a(8'(i), {2'b01, 8'(i ^ 8'h5A)}, 1'((i % 5) == 4), 1'(i & 1), 1, 100000);
        end
        drain();
        rand_rdy = 1'b0;
        m_tready = 3'b111;
        chk("t4_fill_le2", int'(max_fill <= 2), 1);

        // Reset during beat 2 of a 5-beat frame to port 1; next frame goes by its own tdest.
        send_a(8'h51, 10'h150, 1'b0, 1'b0, 1, 0);
        s_tdata = 8'h52; s_tdest = 10'h151; s_tlast = 1'b0; s_tvalid = 1'b1;
        rst = 1'b1;
        qa.delete();
        qb.delete();
        tick();
        chk("t5_tvalid_cleared", int'(m_tvalid), 0);
        chk("t5_tready_low", int'(s_tready), 0);
        rst = 1'b0;
        s_tvalid = 1'b0;
        tick();
        chk("t5_tready_high", int'(s_tready), 1);
        send_a(8'h53, 10'h253, 1'b0, 1'b0, 2, 0);
        send_a(8'h54, 10'h254, 1'b1, 1'b0, 2, 0);
        drain();

        // tlast ignored: alternating sel each beat alternates ports cycle by cycle.
        t0 = cyc;
        for (int i = 0; i < 8; i++) begin
            send_b(8'(8'h60 + i), {1'(i & 1), 8'(8'h80 + i)}, i % 2);
        end
        chk("t6_cycles", cyc - t0, 8);
        drain();

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
